// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI read constants, arbiter FSM states and captured AR control payload.
package axi_read_arbiter_pkg;

    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AXI_RESP_W  = 2;

    localparam logic [AXI_BURST_W-1:0] BURST_INCR  = 2'b01;
    localparam logic [AXI_RESP_W-1:0]  RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    typedef struct packed {
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
    } ar_ctl_t;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// One AXI read port (AR + R channels); master drives AR, slave returns R.
interface axi_read_arbiter_if
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) ();

    logic                   arvalid;
    logic                   arready;
    logic [ADDR_W-1:0]      araddr;
    logic [AXI_LEN_W-1:0]   arlen;
    logic [AXI_SIZE_W-1:0]  arsize;
    logic [ID_W-1:0]        arid;
    logic [AXI_BURST_W-1:0] arburst;

    logic                   rvalid;
    logic                   rready;
    logic [ID_W-1:0]        rid;
    logic [DATA_W-1:0]      rdata;
    logic [AXI_RESP_W-1:0]  rresp;
    logic                   rlast;

    modport master (
        output arvalid, araddr, arlen, arsize, arid, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    // Requesters present no ID/burst type; the arbiter assigns both downstream.
    modport slave (
        input  arvalid, araddr, arlen, arsize, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );

endinterface

// File: rtl/axi_read_arbiter_rr.sv
// Two-way round-robin grant with last-grant register; requester 0 wins first after reset.
module axi_read_arbiter_rr (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt_c
);

    logic last_q;

    // On contention the requester not granted last wins.
    assign gnt_c[1] = req[1] & (~req[0] | ~last_q);
    assign gnt_c[0] = req[0] & (~req[1] |  last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (en && (|req)) begin
            last_q <= gnt_c[1];
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Arbitrates icache (s0) and dcache (s1) AXI reads onto one master, one burst outstanding.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    axi_read_arbiter_if.slave   s0,
    axi_read_arbiter_if.slave   s1,
    axi_read_arbiter_if.master  m
);

    state_e            state;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    ar_ctl_t           ctl_q;
    logic              m_arvalid_q;

    logic [1:0]        req_c;
    logic [1:0]        gnt_c;
    logic              arb_en_c;
    logic [ADDR_W-1:0] req_addr_c;
    ar_ctl_t           req_ctl_c;
    logic              sel0_c;
    logic              sel1_c;

    assign req_c    = {s1.arvalid, s0.arvalid};
    assign arb_en_c = (state == ST_IDLE) && !rst;

    axi_read_arbiter_rr u_rr (
        .clk   (clk),
        .rst   (rst),
        .req   (req_c),
        .en    (arb_en_c),
        .gnt_c (gnt_c)
    );

    assign req_addr_c = gnt_c[1] ? s1.araddr : s0.araddr;

    always_comb begin
        req_ctl_c      = '0;
        req_ctl_c.len  = gnt_c[1] ? s1.arlen  : s0.arlen;
        req_ctl_c.size = gnt_c[1] ? s1.arsize : s0.arsize;
    end

    // Grant/capture in IDLE, present AR in ADDR, stream beats in DATA until rlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            grant_q     <= 1'b0;
            addr_q      <= '0;
            ctl_q       <= '0;
            m_arvalid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_c) begin
                        grant_q     <= gnt_c[1];
                        addr_q      <= req_addr_c;
                        ctl_q       <= req_ctl_c;
                        m_arvalid_q <= 1'b1;
                        state       <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (m.arready) begin
                        m_arvalid_q <= 1'b0;
                        state       <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (m.rvalid && m.rready && m.rlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    m_arvalid_q <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign s0.arready = arb_en_c & gnt_c[0];
    assign s1.arready = arb_en_c & gnt_c[1];

    assign m.arvalid = m_arvalid_q;
    assign m.araddr  = addr_q;
    assign m.arlen   = ctl_q.len;
    assign m.arsize  = ctl_q.size;
    assign m.arid    = ID_W'(grant_q);
    assign m.arburst = BURST_INCR;

    // R routing follows the grant register; m.rid is passed through but never steers.
    assign sel0_c = (state == ST_DATA) && !grant_q;
    assign sel1_c = (state == ST_DATA) &&  grant_q;

    assign m.rready = (sel0_c && s0.rready) || (sel1_c && s1.rready);

    assign s0.rvalid = sel0_c && m.rvalid;
    assign s0.rdata  = sel0_c ? m.rdata : {DATA_W{1'b0}};
    assign s0.rresp  = sel0_c ? m.rresp : RESP_OKAY;
    assign s0.rlast  = sel0_c && m.rlast;
    assign s0.rid    = sel0_c ? m.rid : {ID_W{1'b0}};

    assign s1.rvalid = sel1_c && m.rvalid;
    assign s1.rdata  = sel1_c ? m.rdata : {DATA_W{1'b0}};
    assign s1.rresp  = sel1_c ? m.rresp : RESP_OKAY;
    assign s1.rlast  = sel1_c && m.rlast;
    assign s1.rid    = sel1_c ? m.rid : {ID_W{1'b0}};

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized scoreboard bench for axi_read_arbiter against a transaction-level arbitration model.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s0_if ();
    axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s1_if ();
    axi_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_if ();

    axi_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .s0  (s0_if),
        .s1  (s1_if),
        .m   (m_if)
    );

    // Requester-side stimulus and observed outputs, indexed by requester
    logic              req_arvalid [2];
    logic [ADDR_W-1:0] req_araddr  [2];
    logic [7:0]        req_arlen   [2];
    logic [2:0]        req_arsize  [2];
    logic              req_rready  [2];
    logic              s_arready   [2];
    logic              s_rvalid    [2];
    logic [DATA_W-1:0] s_rdata     [2];
    logic [1:0]        s_rresp     [2];
    logic              s_rlast     [2];
    logic [ID_W-1:0]   s_rid       [2];

    assign s0_if.arvalid = req_arvalid[0];
    assign s0_if.araddr  = req_araddr[0];
    assign s0_if.arlen   = req_arlen[0];
    assign s0_if.arsize  = req_arsize[0];
    assign s0_if.rready  = req_rready[0];
    assign s0_if.arid    = '0;
    assign s0_if.arburst = BURST_INCR;
    assign s1_if.arvalid = req_arvalid[1];
    assign s1_if.araddr  = req_araddr[1];
    assign s1_if.arlen   = req_arlen[1];
    assign s1_if.arsize  = req_arsize[1];
    assign s1_if.rready  = req_rready[1];
    assign s1_if.arid    = '0;
    assign s1_if.arburst = BURST_INCR;

    assign s_arready[0] = s0_if.arready;
    assign s_arready[1] = s1_if.arready;
    assign s_rvalid[0]  = s0_if.rvalid;
    assign s_rvalid[1]  = s1_if.rvalid;
    assign s_rdata[0]   = s0_if.rdata;
    assign s_rdata[1]   = s1_if.rdata;
    assign s_rresp[0]   = s0_if.rresp;
    assign s_rresp[1]   = s1_if.rresp;
    assign s_rlast[0]   = s0_if.rlast;
    assign s_rlast[1]   = s1_if.rlast;
    assign s_rid[0]     = s0_if.rid;
    assign s_rid[1]     = s1_if.rid;

    // Memory-side stimulus
    logic              mem_arready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_rresp;
    logic              mem_rlast;
    logic [ID_W-1:0]   mem_rid;

    assign m_if.arready = mem_arready;
    assign m_if.rvalid  = mem_rvalid;
    assign m_if.rdata   = mem_rdata;
    assign m_if.rresp   = mem_rresp;
    assign m_if.rlast   = mem_rlast;
    assign m_if.rid     = mem_rid;

    typedef enum {M_IDLE, M_ADDR, M_DATA} mphase_t;

    typedef struct {
        int          id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   rid;
    } beat_t;

    int      checks = 0;
    int      passed = 0;
    mphase_t mph = M_IDLE;
    int      m_last = 1;
    int      m_g = 0;
    int      last_arid = -1;
    ar_t     exp_ar [$];
    beat_t   exp_r0 [$];
    beat_t   exp_r1 [$];
    int      mem_q [$];
    int      grant_log [$];
    bit      req_hs [2];
    bit      r_hs = 1'b0;
    int      beats_to [2];
    int      err_beats = 0;
    bit      active = 1'b0;
    int      beat = 0;
    int      blen = 0;
    int      ar_hold = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: arbitration, AR payload and R routing derived from the rules, per cycle.
    task automatic monitor_cycle();
        mphase_t nxt;
        int      g;
        ar_t     a;
        beat_t   b;
        bit      empty;
        nxt = mph;
        for (int n = 0; n < 2; n++) req_hs[n] = req_arvalid[n] && s_arready[n];

        if (mph == M_IDLE && (req_arvalid[0] || req_arvalid[1])) begin
            if (req_arvalid[0] && req_arvalid[1]) g = (m_last == 0) ? 1 : 0;
            else g = req_arvalid[1] ? 1 : 0;
            check("arready_s0", 64'(s_arready[0]), 64'(g == 0));
            check("arready_s1", 64'(s_arready[1]), 64'(g == 1));
            a.id = g; a.addr = req_araddr[g]; a.len = req_arlen[g]; a.size = req_arsize[g];
            exp_ar.push_back(a);
            grant_log.push_back(g);
            m_last = g;
            m_g = g;
            nxt = M_ADDR;
        end else begin
            check("arready_s0_idle", 64'(s_arready[0]), 64'(0));
            check("arready_s1_idle", 64'(s_arready[1]), 64'(0));
        end

        check("m_arvalid", 64'(m_if.arvalid), 64'(mph == M_ADDR));
        if (mph == M_ADDR && exp_ar.size() > 0) begin
            check("m_arid",    64'(m_if.arid),    64'(exp_ar[0].id));
            check("m_araddr",  64'(m_if.araddr),  64'(exp_ar[0].addr));
            check("m_arlen",   64'(m_if.arlen),   64'(exp_ar[0].len));
            check("m_arsize",  64'(m_if.arsize),  64'(exp_ar[0].size));
            check("m_arburst", 64'(m_if.arburst), 64'(2'b01));
            if (mem_arready) begin
                last_arid = int'(m_if.arid);
                a = exp_ar.pop_front();
                mem_q.push_back(int'(a.len));
                nxt = M_DATA;
            end
        end

        check("m_rready", 64'(m_if.rready), 64'((mph == M_DATA) ? req_rready[m_g] : 1'b0));
        for (int n = 0; n < 2; n++)
            check(n == 0 ? "rvalid_s0" : "rvalid_s1", 64'(s_rvalid[n]),
                  64'((mph == M_DATA && m_g == n) ? mem_rvalid : 1'b0));

        r_hs = (mph == M_DATA) && mem_rvalid && req_rready[m_g];
        if (r_hs) begin
            b.data = mem_rdata; b.resp = mem_rresp; b.last = mem_rlast; b.rid = mem_rid;
            if (m_g == 0) exp_r0.push_back(b); else exp_r1.push_back(b);
            if (mem_rlast) nxt = M_IDLE;
        end

        for (int n = 0; n < 2; n++) begin
            if (s_rvalid[n] && req_rready[n]) begin
                beats_to[n]++;
                empty = (n == 0) ? (exp_r0.size() == 0) : (exp_r1.size() == 0);
                if (empty) begin
                    check("r_unexpected", 64'(s_rvalid[n]), 64'(0));
                end else begin
                    b = (n == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                    if (b.resp != RESP_OKAY) err_beats++;
                    check("rdata", 64'(s_rdata[n]), 64'(b.data));
                    check("rresp", 64'(s_rresp[n]), 64'(b.resp));
                    check("rlast", 64'(s_rlast[n]), 64'(b.last));
                    check("rid",   64'(s_rid[n]),   64'(b.rid));
                end
            end
        end
        mph = nxt;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mph = M_IDLE;
                m_last = 1;
                exp_ar.delete();
                exp_r0.delete();
                exp_r1.delete();
                req_hs[0] = 1'b0;
                req_hs[1] = 1'b0;
                r_hs = 1'b0;
            end else begin
                monitor_cycle();
            end
        end
    end

    // Memory slave: random R gaps/errors, garbage rid, stray rvalid while no burst is owed
    initial begin
        mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = RESP_OKAY; mem_rlast = 1'b0; mem_rid = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                mem_q.delete();
                active = 1'b0;
                beat = 0;
                mem_rvalid = 1'b0;
            end else begin
                if (active && r_hs) begin
                    beat++;
                    mem_rvalid = 1'b0;
                    if (beat > blen) active = 1'b0;
                end
                if (!active && mem_q.size() > 0) begin
                    blen = mem_q.pop_front();
                    beat = 0;
                    active = 1'b1;
                    mem_rvalid = 1'b0;
                end
                if (active) begin
                    if (!mem_rvalid && $urandom_range(0, 3) != 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = DATA_W'({$urandom, $urandom});
                        mem_rresp  = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
                        mem_rlast  = (beat == blen);
                        mem_rid    = ID_W'($urandom);
                    end
                end else begin
                    mem_rvalid = ($urandom_range(0, 3) == 0);
                    mem_rlast  = 1'($urandom_range(0, 1));
                    mem_rdata  = DATA_W'({$urandom, $urandom});
                    mem_rresp  = 2'($urandom_range(0, 3));
                    mem_rid    = ID_W'($urandom);
                end
            end
        end
    end

    initial begin
        mem_arready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ar_hold > 0) begin
                mem_arready = 1'b0;
                ar_hold--;
            end else if ($urandom_range(0, 4) == 0) begin
                mem_arready = 1'b0;
                ar_hold = $urandom_range(1, 6);
            end else begin
                mem_arready = 1'b1;
            end
        end
    end

    initial begin
        req_rready[0] = 1'b0;
        req_rready[1] = 1'b0;
        forever begin
            @(posedge clk); #1;
            req_rready[0] = ($urandom_range(0, 3) != 0);
            req_rready[1] = ($urandom_range(0, 3) != 0);
        end
    end

    // Issue cnt requests; payload is scrambled right after each grant
    task automatic requester(input int n, input int cnt, input int gap_max, input int len_fix);
        int gap;
        int wait_c;
        for (int k = 0; k < cnt; k++) begin
            gap = $urandom_range(0, gap_max);
            repeat (gap) begin @(posedge clk); #1; end
            req_arvalid[n] = 1'b1;
            req_araddr[n]  = ADDR_W'($urandom) & ~ADDR_W'(7);
            req_arlen[n]   = (len_fix >= 0) ? 8'(len_fix) : 8'($urandom_range(0, 7));
            req_arsize[n]  = 3'($urandom_range(0, 3));
            wait_c = 0;
            do begin
                @(posedge clk); #1;
                wait_c++;
            end while (!req_hs[n] && wait_c < 3000);
            check("ar_grant_timeout", 64'(req_hs[n]), 64'(1));
            req_arvalid[n] = 1'b0;
            req_araddr[n]  = ADDR_W'($urandom);
            req_arlen[n]   = 8'($urandom);
            req_arsize[n]  = 3'($urandom);
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((mph != M_IDLE || exp_ar.size() > 0 || mem_q.size() > 0 || active) && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_idle", 64'(mph == M_IDLE && !active), 64'(1));
        check("drain_r0_empty", 64'(exp_r0.size()), 64'(0));
        check("drain_r1_empty", 64'(exp_r1.size()), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_arvalid"}, 64'(m_if.arvalid), 64'(0));
        check({tag, "_m_rready"},  64'(m_if.rready),  64'(0));
        check({tag, "_m_araddr"},  64'(m_if.araddr),  64'(0));
        check({tag, "_m_arlen"},   64'(m_if.arlen),   64'(0));
        check({tag, "_m_arid"},    64'(m_if.arid),    64'(0));
        for (int n = 0; n < 2; n++) begin
            check({tag, "_arready"}, 64'(s_arready[n]), 64'(0));
            check({tag, "_rvalid"},  64'(s_rvalid[n]),  64'(0));
        end
    endtask

    initial begin
        int base;
        int glen;
        int c;
        for (int n = 0; n < 2; n++) begin
            req_arvalid[n] = 1'b0;
            req_araddr[n]  = '0;
            req_arlen[n]   = '0;
            req_arsize[n]  = '0;
            beats_to[n]    = 0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Both requesters continuously valid out of reset: grants must alternate from 0
        fork
            requester(0, 6, 0, -1);
            requester(1, 6, 0, -1);
        join
        drain();
        check("fair_grant_count", 64'(grant_log.size()), 64'(12));
        for (int i = 0; i < grant_log.size() && i < 12; i++)
            check("fair_grant_order", 64'(grant_log[i]), 64'(i % 2));

        fork
            requester(0, 25, 8, -1);
            requester(1, 25, 8, -1);
        join
        drain();

        // Reset after the first beat of an 8-beat burst to s1
        base = beats_to[1];
        requester(1, 1, 0, 7);
        c = 0;
        while (beats_to[1] == base && c < 1000) begin @(posedge clk); #1; c++; end
        check("midburst_first_beat", 64'(beats_to[1] - base), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        check_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        glen = grant_log.size();
        requester(1, 1, 2, 3);
        check("post_reset_grant", 64'(grant_log.size() > glen ? grant_log[glen] : -1), 64'(1));
        drain();
        check("post_reset_arid", 64'(last_arid), 64'(1));
        check("post_reset_s0_beats", 64'(exp_r0.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
